// File: rtl/slot_dispatcher_if.sv
// Stream bundle for slot_dispatcher: one inbound AXI-Stream port and NUM_SLOTS+1
// outbound ports (the last outbound port is the loopback).
interface slot_dispatcher_if #(
    parameter int NUM_SLOTS = 2,
    parameter int WIDTH     = 600
);
    logic [WIDTH-1:0]                 rx_TDATA;
    logic                             rx_TVALID;
    logic                             rx_TREADY;
    logic [(NUM_SLOTS+1)*WIDTH-1:0]   tx_TDATA;
    logic [NUM_SLOTS:0]               tx_TVALID;
    logic [NUM_SLOTS:0]               tx_TREADY;

    modport master (
        output rx_TDATA, rx_TVALID,
        input  rx_TREADY,
        input  tx_TDATA, tx_TVALID,
        output tx_TREADY
    );

    modport slave (
        input  rx_TDATA, rx_TVALID,
        output rx_TREADY,
        output tx_TDATA, tx_TVALID,
        input  tx_TREADY
    );
endinterface

// File: rtl/slot_dispatcher.sv
// Routes inbound beats to per-slot FIFOs by block_id, sends reset headers and
// overflow (when spilling is enabled) to a loopback FIFO, and emits a soft reset pulse.
module slot_dispatcher #(
    parameter int NUM_SLOTS  = 2,
    parameter int WIDTH      = 600,
    parameter int FIFO_DEPTH = 4,
    parameter int SPILL_EN   = 1
) (
    input  logic               clk,
    input  logic               rst,
    slot_dispatcher_if.slave   bus,
    output logic               soft_rst,
    output logic [29:0]        num_workers,
    output logic [31:0]        spill_count
);
    localparam int NUM_PORTS = NUM_SLOTS + 1;
    localparam int LB        = NUM_SLOTS;
    localparam int PTR_W     = $clog2(FIFO_DEPTH);
    localparam int IDX_W     = $clog2(NUM_PORTS);
    localparam logic [29:0]      SLOTS30 = 30'(NUM_SLOTS);
    localparam logic [IDX_W-1:0] LB_IDX  = IDX_W'(NUM_SLOTS);

    logic [NUM_PORTS-1:0] full;
    logic [NUM_PORTS-1:0] wr_en;
    logic [NUM_PORTS-1:0] rd_en;

    logic             hdr;
    logic [IDX_W-1:0] slot_idx;
    logic [IDX_W-1:0] dest;
    logic             ready;
    logic             spill;
    logic             accept;

    logic        pulse_q, pulse_d;
    logic [29:0] num_workers_q, num_workers_d;
    logic [31:0] spill_count_q, spill_count_d;

    // Routing decision looks only at full flags, so a same-cycle pop never frees a slot.
    always_comb begin
        hdr      = bus.rx_TDATA[0];
        slot_idx = IDX_W'(bus.rx_TDATA[31:2] % SLOTS30);
        ready    = 1'b0;
        dest     = LB_IDX;
        spill    = 1'b0;
        if (!rst) begin
            if (hdr) begin
                ready = !full[LB];
            end else if (!full[slot_idx]) begin
                ready = 1'b1;
                dest  = slot_idx;
            end else if (SPILL_EN != 0 && !full[LB]) begin
                ready = 1'b1;
                spill = 1'b1;
            end
        end
    end

    assign accept        = bus.rx_TVALID & ready;
    assign bus.rx_TREADY = ready;

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_fifo
            logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
            logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
            logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;

            assign wr_en[gi] = accept && (dest == IDX_W'(gi));
            assign rd_en[gi] = bus.tx_TVALID[gi] & bus.tx_TREADY[gi];

            always_comb begin
                wr_ptr_d = wr_ptr_q + {{PTR_W{1'b0}}, wr_en[gi]};
                rd_ptr_d = rd_ptr_q + {{PTR_W{1'b0}}, rd_en[gi]};
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                end else begin
                    wr_ptr_q <= wr_ptr_d;
                    rd_ptr_q <= rd_ptr_d;
                end
            end

            always_ff @(posedge clk) begin
                if (wr_en[gi]) begin
                    mem_q[wr_ptr_q[PTR_W-1:0]] <= bus.rx_TDATA;
                end
            end

            // Extra pointer bit distinguishes full from empty when the indices match.
            assign full[gi]          = (wr_ptr_q ^ rd_ptr_q) == {1'b1, {PTR_W{1'b0}}};
            assign bus.tx_TVALID[gi] = (wr_ptr_q != rd_ptr_q);
            assign bus.tx_TDATA[gi*WIDTH +: WIDTH] = mem_q[rd_ptr_q[PTR_W-1:0]];
        end
    endgenerate

    always_comb begin
        pulse_d       = accept & hdr;
        num_workers_d = (accept & hdr) ? bus.rx_TDATA[31:2] : num_workers_q;
        spill_count_d = spill_count_q;
        if (accept && spill && spill_count_q != 32'hFFFF_FFFF) begin
            spill_count_d = spill_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pulse_q       <= 1'b0;
            num_workers_q <= '0;
            spill_count_q <= '0;
        end else begin
            pulse_q       <= pulse_d;
            num_workers_q <= num_workers_d;
            spill_count_q <= spill_count_d;
        end
    end

    assign soft_rst    = rst | pulse_q;
    assign num_workers = num_workers_q;
    assign spill_count = spill_count_q;
endmodule

// File: tb/tb_slot_dispatcher.sv
// Drives a spilling and a stalling slot_dispatcher with identical stimulus and checks
// the selected one against a per-port scoreboard and occupancy model.
module tb_slot_dispatcher;
    localparam int NS = 2;
    localparam int W  = 600;
    localparam int D  = 4;
    localparam int NP = NS + 1;
    localparam int LB = NS;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  rx_data;
    logic          rx_valid;
    logic [NP-1:0] tx_ready;

    always #5 clk = ~clk;

    slot_dispatcher_if #(.NUM_SLOTS(NS), .WIDTH(W)) bus_a ();
    slot_dispatcher_if #(.NUM_SLOTS(NS), .WIDTH(W)) bus_b ();

    assign bus_a.rx_TDATA  = rx_data;
    assign bus_a.rx_TVALID = rx_valid;
    assign bus_a.tx_TREADY = tx_ready;
    assign bus_b.rx_TDATA  = rx_data;
    assign bus_b.rx_TVALID = rx_valid;
    assign bus_b.tx_TREADY = tx_ready;

    logic        soft_a, soft_b;
    logic [29:0] nw_a, nw_b;
    logic [31:0] sc_a, sc_b;

    slot_dispatcher #(.NUM_SLOTS(NS), .WIDTH(W), .FIFO_DEPTH(D), .SPILL_EN(1)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a),
        .soft_rst(soft_a), .num_workers(nw_a), .spill_count(sc_a)
    );

    slot_dispatcher #(.NUM_SLOTS(NS), .WIDTH(W), .FIFO_DEPTH(D), .SPILL_EN(0)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b),
        .soft_rst(soft_b), .num_workers(nw_b), .spill_count(sc_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [W-1:0] exp_q [NP][$];
    int           cnt [NP];
    logic         pulse_exp;
    logic [29:0]  nw_exp;
    logic [31:0]  sc_exp;
    int           mode;
    bit           spill_en;
    bit           last_acc;
    bit           rand_ready;

    task automatic check_val(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s (mode %0d): got %0h expected %0h", tag, mode, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < NP; i++) begin
            exp_q[i].delete();
            cnt[i] = 0;
        end
        pulse_exp = 1'b0;
        nw_exp    = '0;
        sc_exp    = '0;
    endtask

    function automatic logic [W-1:0] mk(input logic [29:0] id, input bit hdr);
        logic [W-1:0] v;
        for (int k = 0; k < W; k++) v[k] = 1'($urandom_range(0, 1));
        v[31:0] = {id, 1'b0, hdr};
        return v;
    endfunction

    // One clock: called at a falling edge with inputs already applied, returns at the next one.
    task automatic cycle();
        logic [NP-1:0]   tv;
        logic            rr, sr;
        logic [29:0]     nw;
        logic [31:0]     sc;
        logic [NP*W-1:0] td;
        bit              hdr, ready, spill;
        int              slot, dest;
        #1;
        if (mode == 0) begin
            tv = bus_a.tx_TVALID; rr = bus_a.rx_TREADY; td = bus_a.tx_TDATA;
            sr = soft_a; nw = nw_a; sc = sc_a;
        end else begin
            tv = bus_b.tx_TVALID; rr = bus_b.rx_TREADY; td = bus_b.tx_TDATA;
            sr = soft_b; nw = nw_b; sc = sc_b;
        end
        check_val("soft_rst", W'(sr), W'(rst | pulse_exp));
        check_val("num_workers", W'(nw), W'(nw_exp));
        check_val("spill_count", W'(sc), W'(sc_exp));

        hdr   = rx_data[0];
        slot  = int'(rx_data[31:2] % 30'(NS));
        ready = 1'b0;
        spill = 1'b0;
        dest  = LB;
        if (!rst) begin
            if (hdr) begin
                ready = (cnt[LB] < D);
            end else if (cnt[slot] < D) begin
                ready = 1'b1;
                dest  = slot;
            end else if (spill_en && cnt[LB] < D) begin
                ready = 1'b1;
                spill = 1'b1;
            end
        end
        check_val("rx_TREADY", W'(rr), W'(ready));

        for (int i = 0; i < NP; i++) begin
            check_val($sformatf("tx_TVALID[%0d]", i), W'(tv[i]), W'(cnt[i] != 0));
            if (cnt[i] > 0 && tx_ready[i]) begin
                check_val($sformatf("tx_TDATA[%0d]", i), td[i*W +: W], exp_q[i].pop_front());
                cnt[i]--;
            end
        end

        last_acc = rx_valid && ready;
        if (last_acc) begin
            exp_q[dest].push_back(rx_data);
            cnt[dest]++;
            if (spill && sc_exp != 32'hFFFF_FFFF) sc_exp++;
            if (hdr) nw_exp = rx_data[31:2];
            $display("t=%0t mode=%0d beat id=%0d hdr=%0d -> port %0d%s", $time, mode,
                     rx_data[31:2], hdr, dest, spill ? " (spill)" : "");
        end
        pulse_exp = last_acc && hdr;
        if (rst) clear_model();
        @(negedge clk);
    endtask

    task automatic send(input logic [W-1:0] d);
        rx_data  = d;
        rx_valid = 1'b1;
        last_acc = 1'b0;
        for (int k = 0; k < 64 && !last_acc; k++) begin
            if (rand_ready) tx_ready = NP'($urandom);
            cycle();
        end
        check_val("send_accepted", W'(last_acc), W'(1'b1));
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (rand_ready) tx_ready = NP'($urandom);
            cycle();
        end
    endtask

    task automatic reset_all();
        rst      = 1'b1;
        rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_model();
    endtask

    initial begin
        logic [W-1:0] d;
        rst        = 1'b1;
        rx_valid   = 1'b0;
        rx_data    = '0;
        tx_ready   = '1;
        rand_ready = 1'b0;
        mode       = 0;
        clear_model();
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            mode     = m;
            spill_en = (m == 0);
            reset_all();
            rand_ready = 1'b0;
            tx_ready   = '1;
            idle(1);

            // Round-robin block ids onto the slots
            for (int id = 0; id < 4; id++) send(mk(30'(id), 1'b0));
            idle(3);

            // Reset header with num_workers = 4 (TDATA[31:0] = 0x11)
            send(mk(30'd4, 1'b1));
            idle(3);

            // Fill slot 0, then overflow it
            tx_ready = 3'b110;
            for (int k = 0; k < 6; k++) begin
                d = mk(30'd0, 1'b0);
                if (k == 4 && m == 1) begin
                    rx_data  = d;
                    rx_valid = 1'b1;
                    repeat (3) cycle();
                    tx_ready[0] = 1'b1;
                end
                send(d);
            end
            tx_ready = '1;
            idle(6);

            // Reset header held while loopback is full
            tx_ready = 3'b011;
            for (int k = 0; k < 4; k++) send(mk(30'(k + 1), 1'b1));
            d        = mk(30'd9, 1'b1);
            rx_data  = d;
            rx_valid = 1'b1;
            repeat (3) cycle();
            tx_ready = '1;
            send(d);
            idle(6);

            // Random backpressure stress
            rand_ready = 1'b1;
            for (int k = 0; k < 150; k++) begin
                if ($urandom_range(0, 3) != 0)
                    send(mk(30'($urandom_range(0, 50)), $urandom_range(0, 7) == 0));
                else
                    idle(1);
            end
            rand_ready = 1'b0;
            tx_ready   = '1;
            idle(8);

            // Reset mid-operation with partially full FIFOs; a header offered during reset is dropped
            tx_ready = '0;
            send(mk(30'd0, 1'b0));
            send(mk(30'd1, 1'b0));
            send(mk(30'd3, 1'b0));
            send(mk(30'd7, 1'b1));
            rx_data  = mk(30'd2, 1'b1);
            rx_valid = 1'b1;
            rst      = 1'b1;
            cycle();
            rst      = 1'b0;
            rx_valid = 1'b0;
            tx_ready = '1;
            idle(3);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/slot_dispatcher.md
SLOT_DISPATCHER -- requirements
Module: slot_dispatcher

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 2, number of worker slot output ports (>=1).
REQ-002 SHALL have parameter WIDTH, default 600 (512+88), beat width in bits (>=32).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, entries per output FIFO (power of 2, >=2).
REQ-004 SHALL have parameter SPILL_EN, default 1; 1 = divert data for a full slot to loopback, 0 = stall input.
REQ-005 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port rx_TDATA  input  WIDTH  inbound beat; [31:2] block_id/num_workers, [0] header_rst flag.
REQ-008 SHALL have ports rx_TVALID input 1 and rx_TREADY output 1, inbound AXI-Stream handshake.
REQ-009 SHALL have port tx_TDATA  output  (NUM_SLOTS+1)*WIDTH  port i at bits [(i+1)*WIDTH-1 : i*WIDTH]; port NUM_SLOTS is loopback.
REQ-010 SHALL have ports tx_TVALID output NUM_SLOTS+1 and tx_TREADY input NUM_SLOTS+1, per-port handshake.
REQ-011 SHALL have port soft_rst  output  1  downstream reset pulse.
REQ-012 SHALL have port num_workers  output  30  last num_workers field received in a reset header.
REQ-013 SHALL have port spill_count  output  32  beats diverted to loopback because their slot was full.

Function
REQ-014 SHALL provide one FIFO per output port (NUM_SLOTS+1 total), FIFO_DEPTH entries of WIDTH bits; tx_TVALID[i] = FIFO i non-empty; tx_TDATA slice i = FIFO i head.
REQ-015 SHALL pop FIFO i on the cycle tx_TVALID[i] & tx_TREADY[i]; in-order per port.
REQ-016 SHALL accept an input beat only on rx_TVALID & rx_TREADY; rx_TREADY combinational from FIFO full flags and routing decision, never from tx_TREADY directly.
REQ-017 SHALL route accepted beat with header_rst=1 to loopback FIFO; rx_TREADY = !full(loopback).
REQ-018 SHALL route beat with header_rst=0 to slot s = block_id mod NUM_SLOTS (unsigned, 30-bit) when FIFO s not full.
REQ-019 When FIFO s full and SPILL_EN=1: SHALL route to loopback if not full, increment spill_count; if loopback also full, rx_TREADY=0.
REQ-020 When FIFO s full and SPILL_EN=0: rx_TREADY=0; no spill, spill_count unchanged.
REQ-021 Full-flag check SHALL ignore a same-cycle pop (no write-through): a full FIFO refuses a write even if popped that cycle.
REQ-022 Latency: beat accepted in cycle N SHALL appear as tx_TVALID on its port in cycle N+1 when that FIFO was empty; one beat per cycle sustained.
REQ-023 On acceptance of a header_rst=1 beat, num_workers SHALL load rx_TDATA[31:2] in the next cycle.
REQ-024 soft_rst SHALL be a registered pulse high exactly one cycle (N+1) per accepted header_rst=1 beat in cycle N; back-to-back reset headers yield back-to-back pulses.
REQ-025 A non-accepted (rx_TVALID=0 or stalled) reset header SHALL NOT pulse soft_rst or change num_workers.
REQ-026 spill_count SHALL saturate at 0xFFFF_FFFF.
REQ-027 soft_rst SHALL NOT clear FIFOs, num_workers or spill_count internally.

Reset
REQ-028 While rst=1 at a clock edge: all FIFOs empty, tx_TVALID=0, num_workers=0, spill_count=0, pulse register cleared.
REQ-029 soft_rst SHALL equal rst OR pulse register (high throughout rst).
REQ-030 rx_TREADY SHALL be 0 while rst=1; beats presented during rst are dropped; FIFO contents lost on rst mid-operation.

Verification
REQ-031 NUM_SLOTS=2, all tx_TREADY=1: beats block_id 0,1,2,3 (header_rst=0) -> ports 0,1,0,1 each one cycle later, spill_count=0.
REQ-032 Header 0x0000_0011 (num_workers=4, rst flag) accepted cycle N -> loopback beat cycle N+1, soft_rst high only cycle N+1, num_workers=4.
REQ-033 SPILL_EN=1, FIFO_DEPTH=4, tx_TREADY[0]=0: six block_id=0 beats -> first 4 in FIFO 0, next 2 on loopback, spill_count=2, rx_TREADY stays 1.
REQ-034 SPILL_EN=0, same stimulus -> rx_TREADY=0 after 4th beat; releasing tx_TREADY[0] pops one, rx_TREADY=1 next cycle, no loopback traffic.
REQ-035 rst asserted with all FIFOs partially full -> next cycle tx_TVALID=0, spill_count=0, num_workers=0, soft_rst=1 during rst, rx_TREADY=0.
REQ-036 Reset header held with loopback full -> no soft_rst pulse until accepted; random tx_TREADY stress checks per-port order and no loss/duplication.
